// File: rtl/mux_demux_channel_scheduler_2.sv
// Round-robin scheduler for a shared 2:1 mux / 1:2 demux channel between two
// valid/ready lanes, with bounded bursts and a single output holding register.

module mux_demux_channel_scheduler_2_mux #(
  parameter int ID    = 1,
  parameter int WIDTH = 2
) (
  input  logic                  sel,
  input  logic [1:0][WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]      out_data
);
  assign out_data = in_data[sel];
endmodule

module mux_demux_channel_scheduler_2_demux #(
  parameter int ID    = 1,
  parameter int WIDTH = 2
) (
  input  logic                  sel,
  input  logic [WIDTH-1:0]      in_data,
  output logic [1:0][WIDTH-1:0] out_data
);
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    out_data      = '0;
    out_data[sel] = in_data;
  end
endmodule

module mux_demux_channel_scheduler_2 #(
  parameter int ID        = 1,
  parameter int WIDTH     = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [1:0][WIDTH-1:0] in_data,
  input  logic [1:0]            in_valid,
  output logic [1:0]            in_ready,
  output logic [1:0][WIDTH-1:0] out_data,
  output logic [1:0]            out_valid,
  input  logic [1:0]            out_ready,
  output logic                  sel,
  output logic                  busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  function automatic state_t grant_state(input logic lane);
    return lane ? GRANT1 : GRANT0;
  endfunction

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             tag_q, tag_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sel_q, sel_d;
  logic             busy_q, busy_d;

  logic                  granted;
  logic                  grant;
  logic                  can_accept;
  logic                  fire;
  logic                  limit;
  logic [WIDTH-1:0]      mux_data;
  logic [1:0][WIDTH-1:0] demux_data;

  assign granted    = (state_q != IDLE);
  assign grant      = (state_q == GRANT1);
  // A full register can still take a new word in the cycle it drains.
  assign can_accept = !full_q || out_ready[tag_q];
  assign fire       = granted && can_accept && in_valid[grant];
  assign limit      = fire && (cnt_q == CNT_W'(MAX_BURST - 1));

  assign in_ready[0] = (state_q == GRANT0) && can_accept;
  assign in_ready[1] = (state_q == GRANT1) && can_accept;

  (* keep *) mux_demux_channel_scheduler_2_mux #(
    .ID    (ID),
    .WIDTH (WIDTH)
  ) u_mux (
    .sel      (grant),
    .in_data  (in_data),
    .out_data (mux_data)
  );

  (* keep *) mux_demux_channel_scheduler_2_demux #(
    .ID    (ID),
    .WIDTH (WIDTH)
  ) u_demux (
    .sel      (grant),
    .in_data  (mux_data),
    .out_data (demux_data)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (in_valid[~last_q]) begin
          state_d = grant_state(~last_q);
        end else if (in_valid[last_q]) begin
          state_d = grant_state(last_q);
        end
      end
      GRANT0, GRANT1: begin
        if (limit) begin
          cnt_d = '0;
          if (in_valid[~grant]) begin
            state_d = grant_state(~grant);
            last_d  = grant;
          end
        end else if (!in_valid[grant]) begin
          cnt_d   = '0;
          last_d  = grant;
          state_d = in_valid[~grant] ? grant_state(~grant) : IDLE;
        end else if (fire) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    full_d = full_q;
    tag_d  = tag_q;
    data_d = data_q;
    if (fire) begin
      full_d = 1'b1;
      tag_d  = grant;
      data_d = demux_data[grant];
    end else if (full_q && out_ready[tag_q]) begin
      full_d = 1'b0;
    end
  end

  // sel and busy are registered copies of the next state.
  always_comb begin
    sel_d  = (state_d == GRANT1);
    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      tag_q   <= 1'b0;
      // NOTE: the held word is a plain register, so it is reset to keep out_data zero after reset.
      data_q  <= '0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    out_valid         = '0;
    out_data          = '0;
    out_valid[tag_q]  = full_q;
    out_data[tag_q]   = data_q;
  end

  assign sel  = sel_q;
  assign busy = busy_q;

endmodule
